riscv_div_seq: RTL and testbench

Iterative 32-bit divide/remainder sequencer that owns no arithmetic datapath of its own: it drives a shared basic ALU through that ALU's operator/operand port set and consumes its result and comparison outputs. It sits in the EX stage beside the basic ALU. Toward the pipeline it presents the same ready/ex_ready handshake as the other EX units.

---
 rtl/riscv_div_seq.sv | 176 +++++++++++++++++
 tb/tb_riscv_div_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_div_seq.sv
// riscv_div_seq: iterative 32-bit DIV/DIVU/REM/REMU sequencer.
// It owns no adder or comparator; every subtraction, negation and unsigned
// compare is sent to the shared EX-stage ALU and the result is used in the same cycle.
// Optional build macro: RISCV_DIV_SKIP_SUB_EN. When it is defined, a CMP step that
// finds no subtraction is needed skips the SUB cycle.

package riscv_defines;
    localparam int ALU_OP_WIDTH = 7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = 7'b0011001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU = 7'b0001011;
endpackage

module riscv_div_seq
    import riscv_defines::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    div_valid_i,
    input  logic [1:0]              div_op_i,
    input  logic [31:0]             op_a_i,
    input  logic [31:0]             op_b_i,
    output logic [31:0]             result_o,
    output logic                    ready_o,
    input  logic                    ex_ready_i,
    output logic [ALU_OP_WIDTH-1:0] alu_operator_o,
    output logic [31:0]             alu_operand_a_o,
    output logic [31:0]             alu_operand_b_o,
    input  logic [31:0]             alu_result_i,
    input  logic                    alu_comparison_result_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_ABS_A, S_ABS_B, S_CMP, S_SUB, S_FIX, S_DONE
    } state_e;

    // Bit 0 of the operation selects signed, and bit 1 selects remainder.
    state_e      state_q;
    logic [1:0]  op_q;
    logic        sign_a_q, sign_b_q;
    logic [31:0] rem_q, quo_q, divisor_q, result_q;
    logic        ge_q;
    logic [4:0]  cnt_q;

    logic [31:0] shift_rem_d;   // remainder shifted left, with the next dividend bit shifted in
    logic        cmp_ge_d;      // quotient bit for this iteration
    logic [31:0] sub_rem_d;     // remainder after the conditional subtract
    logic [31:0] fix_val_d;     // unsigned result that FIX may negate
    logic        fix_neg_d;

    assign shift_rem_d = {rem_q[30:0], quo_q[31]};
    // The shifted-out bit rem_q[31] means s is at least 2^32, so s must exceed the divisor.
    assign cmp_ge_d    = alu_comparison_result_i | rem_q[31];
    assign sub_rem_d   = ge_q ? alu_result_i : rem_q;
    assign fix_val_d   = op_q[1] ? rem_q : quo_q;
    assign fix_neg_d   = op_q[1] ? sign_a_q : (sign_a_q ^ sign_b_q);

    assign result_o = result_q;
    assign ready_o  = (state_q == S_IDLE) || (state_q == S_DONE);

    // Drive the shared ALU from the current state and registers.
    always_comb begin
        // NOTE: defaults first so that no path through the case leaves an output unassigned, which would infer a latch.
        alu_operator_o  = ALU_ADD;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        unique case (state_q)
            S_ABS_A: begin alu_operator_o = ALU_SUB; alu_operand_b_o = quo_q;     end
            S_ABS_B: begin alu_operator_o = ALU_SUB; alu_operand_b_o = divisor_q; end
            S_CMP: begin
                alu_operator_o  = ALU_GEU;
                alu_operand_a_o = shift_rem_d;
                alu_operand_b_o = divisor_q;
            end
            S_SUB: begin
                alu_operator_o  = ALU_SUB;
                alu_operand_a_o = rem_q;
                alu_operand_b_o = divisor_q;
            end
            S_FIX:   begin alu_operator_o = ALU_SUB; alu_operand_b_o = fix_val_d; end
            default: ;
        endcase
    end

    // Sequencer FSM: operand capture, restoring-division iterations, sign fix-up and result handshake.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and clears every register, so the state after reset never depends on an earlier operation.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            ge_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every branch reads values from before the edge.
            unique case (state_q)
                S_IDLE: begin
                    if (div_valid_i) begin
                        op_q      <= div_op_i;
                        sign_a_q  <= div_op_i[0] & op_a_i[31];
                        sign_b_q  <= div_op_i[0] & op_b_i[31];
                        quo_q     <= op_a_i;
                        divisor_q <= op_b_i;
                        rem_q     <= '0;
                        ge_q      <= 1'b0;
                        cnt_q     <= '0;
                        if (op_b_i == '0) begin
                            result_q <= div_op_i[1] ? op_a_i : '1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= div_op_i[0] ? S_ABS_A : S_CMP;
                        end
                    end
                end
                S_ABS_A: begin
                    if (sign_a_q) quo_q <= alu_result_i;
                    state_q <= S_ABS_B;
                end
                S_ABS_B: begin
                    if (sign_b_q) divisor_q <= alu_result_i;
                    state_q <= S_CMP;
                end
                S_CMP: begin
                    ge_q  <= cmp_ge_d;
                    rem_q <= shift_rem_d;
                    quo_q <= {quo_q[30:0], cmp_ge_d};
`ifdef RISCV_DIV_SKIP_SUB_EN
                    if (!cmp_ge_d) begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            if (op_q[0]) begin
                                state_q <= S_FIX;
                            end else begin
                                result_q <= op_q[1] ? shift_rem_d : {quo_q[30:0], 1'b0};
                                state_q  <= S_DONE;
                            end
                        end
                    end else begin
                        state_q <= S_SUB;
                    end
`else
                    state_q <= S_SUB;
`endif
                end
                S_SUB: begin
                    rem_q <= sub_rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        if (op_q[0]) begin
                            state_q <= S_FIX;
                        end else begin
                            result_q <= op_q[1] ? sub_rem_d : quo_q;
                            state_q  <= S_DONE;
                        end
                    end else begin
                        state_q <= S_CMP;
                    end
                end
                S_FIX: begin
                    result_q <= fix_neg_d ? alu_result_i : fix_val_d;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    if (ex_ready_i) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div_seq.sv
// Testbench for riscv_div_seq. A combinational ALU model is attached to the sequencer.
// Results and latencies are compared with a reference that uses plain arithmetic.

module tb_riscv_div_seq;
    import riscv_defines::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    div_valid_i = 1'b0;
    logic [1:0]              div_op_i = '0;
    logic [31:0]             op_a_i = '0;
    logic [31:0]             op_b_i = '0;
    logic [31:0]             result_o;
    logic                    ready_o;
    logic                    ex_ready_i = 1'b0;
    logic [ALU_OP_WIDTH-1:0] alu_operator_o;
    logic [31:0]             alu_operand_a_o, alu_operand_b_o;
    logic [31:0]             alu_result_i;
    logic                    alu_comparison_result_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [1:0] OP_DIVU = 2'b00, OP_DIV = 2'b01, OP_REMU = 2'b10, OP_REM = 2'b11;

    riscv_div_seq dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .div_valid_i             (div_valid_i),
        .div_op_i                (div_op_i),
        .op_a_i                  (op_a_i),
        .op_b_i                  (op_b_i),
        .result_o                (result_o),
        .ready_o                 (ready_o),
        .ex_ready_i              (ex_ready_i),
        .alu_operator_o          (alu_operator_o),
        .alu_operand_a_o         (alu_operand_a_o),
        .alu_operand_b_o         (alu_operand_b_o),
        .alu_result_i            (alu_result_i),
        .alu_comparison_result_i (alu_comparison_result_i)
    );

    always #5 clk = ~clk;

    // Shared basic ALU, modelled as combinational.
    always_comb begin
        alu_result_i            = '0;
        alu_comparison_result_i = 1'b0;
        case (alu_operator_o)
            ALU_ADD: alu_result_i = alu_operand_a_o + alu_operand_b_o;
            ALU_SUB: alu_result_i = alu_operand_a_o - alu_operand_b_o;
            ALU_GEU: alu_comparison_result_i = (alu_operand_a_o >= alu_operand_b_o);
            default: ;
        endcase
    end

    // RISC-V M-extension divide/remainder semantics.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            OP_DIVU: return a / b;
            OP_REMU: return a % b;
            OP_DIV:  return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            default: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
        endcase
    endfunction

    // Edge at which DONE is entered, counted from the accept edge.
    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub;
        ua = (op[0] && a[31]) ? -a : a;
        ub = (op[0] && b[31]) ? -b : b;
        if (b == 32'd0) return 1;
`ifdef RISCV_DIV_SKIP_SUB_EN
        return 33 + $countones(ua / ub) + (op[0] ? 3 : 0);
`else
        if (ua == ub) return op[0] ? 68 : 65;   // keeps ua/ub used in the default build
        return op[0] ? 68 : 65;
`endif
    endfunction

    // Issues one request while in IDLE, waits a bounded time for DONE, optionally
    // holds DONE under backpressure, then releases the request. The call returns #1 after the release edge.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit poke,
                         output int lat, output logic [31:0] res, output bit stable);
        stable = 1'b1;
        div_valid_i = 1'b1;
        div_op_i = op;
        op_a_i = a;
        op_b_i = b;
        @(posedge clk); #1;
        div_valid_i = 1'b0;
        div_op_i = 2'($urandom_range(3));
        op_a_i = $urandom;
        op_b_i = $urandom;
        lat = 1;
        while (!ready_o && lat < 200) begin
            if (poke && lat == 4) div_valid_i = 1'b1;
            if (poke && lat == 9) div_valid_i = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        div_valid_i = 1'b0;
        res = result_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (result_o !== res || ready_o !== 1'b1) stable = 1'b0;
        end
        ex_ready_i = 1'b1;
        @(posedge clk); #1;
        ex_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (result_o !== 32'd0) $display("FAIL reset_result got %h want %h", result_o, 32'd0); else pass_cnt++;
        total_cnt++;
        if (ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", ready_o); else pass_cnt++;
        total_cnt++;
        if (alu_operator_o !== ALU_ADD) $display("FAIL reset_alu_op got %h want %h", alu_operator_o, ALU_ADD); else pass_cnt++;
        total_cnt++;
        if ({alu_operand_a_o, alu_operand_b_o} !== 64'd0)
            $display("FAIL reset_alu_operands got %h/%h want 0/0", alu_operand_a_o, alu_operand_b_o);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, exp;
    } vec_t;

    task automatic test_directed();
        vec_t v[8];
        int lat;
        logic [31:0] res;
        bit st;
        v[0] = '{OP_DIVU, 32'd100,         32'd7,           32'd14};
        v[1] = '{OP_REMU, 32'd100,         32'd7,           32'd2};
        v[2] = '{OP_DIV,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD};
        v[3] = '{OP_REM,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF};
        v[4] = '{OP_DIV,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000};
        v[5] = '{OP_REM,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0};
        v[6] = '{OP_DIVU, 32'hFFFF_FFFF,   32'h8000_0001,   32'd1};
        v[7] = '{OP_REMU, 32'hFFFF_FFFF,   32'h8000_0001,   32'h7FFF_FFFE};
        for (int i = 0; i < 8; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, 0, 1'b0, lat, res, st);
            total_cnt++;
            if (res !== v[i].exp) $display("FAIL directed%0d_result got %h want %h", i, res, v[i].exp); else pass_cnt++;
            total_cnt++;
            if (lat != ref_latency(v[i].op, v[i].a, v[i].b))
                $display("FAIL directed%0d_latency got %0d want %0d", i, lat, ref_latency(v[i].op, v[i].a, v[i].b));
            else pass_cnt++;
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] want [2];
        want[0] = 32'hFFFF_FFFF;
        want[1] = 32'h0000_1234;
        for (int i = 0; i < 2; i++) begin
            div_valid_i = 1'b1;
            div_op_i = (i == 0) ? OP_DIVU : OP_REMU;
            op_a_i = 32'h1234;
            op_b_i = 32'd0;
            total_cnt++;
            if (alu_operator_o !== ALU_ADD) $display("FAIL divzero%0d_alu_idle got %h want %h", i, alu_operator_o, ALU_ADD); else pass_cnt++;
            @(posedge clk); #1;
            div_valid_i = 1'b0;
            total_cnt++;
            if (ready_o !== 1'b1 || result_o !== want[i])
                $display("FAIL divzero%0d_done got ready=%b result=%h want ready=1 result=%h", i, ready_o, result_o, want[i]);
            else pass_cnt++;
            total_cnt++;
            if (alu_operator_o !== ALU_ADD || alu_operand_a_o !== 32'd0 || alu_operand_b_o !== 32'd0)
                $display("FAIL divzero%0d_alu_done got %h %h %h want %h 0 0", i, alu_operator_o, alu_operand_a_o, alu_operand_b_o, ALU_ADD);
            else pass_cnt++;
            ex_ready_i = 1'b1;
            @(posedge clk); #1;
            ex_ready_i = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] res, a, b;
        bit st;
        a = $urandom;
        b = 32'($urandom_range(1, 5000));
        do_op(OP_DIVU, a, b, 5, 1'b0, lat, res, st);
        total_cnt++;
        if (res !== ref_result(OP_DIVU, a, b)) $display("FAIL backpressure_result got %h want %h", res, ref_result(OP_DIVU, a, b)); else pass_cnt++;
        total_cnt++;
        if (st !== 1'b1) $display("FAIL backpressure_stable got %b want 1", st); else pass_cnt++;
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic [31:0] res, a, b;
        bit st;
        a = $urandom | 32'h8000_0000;
        b = 32'($urandom_range(2, 300));
        do_op(OP_REM, a, b, 0, 1'b1, lat, res, st);
        total_cnt++;
        if (res !== ref_result(OP_REM, a, b)) $display("FAIL busy_ignore_result got %h want %h", res, ref_result(OP_REM, a, b)); else pass_cnt++;
        total_cnt++;
        if (lat != ref_latency(OP_REM, a, b)) $display("FAIL busy_ignore_latency got %0d want %0d", lat, ref_latency(OP_REM, a, b)); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] res;
        bit st;
        do_op(OP_DIV, 32'hFFFF_FF00, 32'd16, 0, 1'b0, lat, res, st);
        total_cnt++;
        if (ready_o !== 1'b1) $display("FAIL b2b_idle_ready got %b want 1", ready_o); else pass_cnt++;
        do_op(OP_DIVU, 32'd1000, 32'd3, 0, 1'b0, lat, res, st);
        total_cnt++;
        if (res !== 32'd333) $display("FAIL b2b_second_result got %h want %h", res, 32'd333); else pass_cnt++;
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] res, a, b;
        logic [1:0] op;
        bit st;
        for (int n = 0; n < 24; n++) begin
            op = 2'($urandom_range(3));
            a = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(3));
                default: b = $urandom;
            endcase
            do_op(op, a, b, 0, 1'b0, lat, res, st);
            total_cnt++;
            if (res !== ref_result(op, a, b))
                $display("FAIL random%0d_result op=%0d a=%h b=%h got %h want %h", n, op, a, b, res, ref_result(op, a, b));
            else pass_cnt++;
            total_cnt++;
            if (lat != ref_latency(op, a, b))
                $display("FAIL random%0d_latency got %0d want %0d", n, lat, ref_latency(op, a, b));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] res;
        bit st;
        do_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b0, lat, res, st);
        div_valid_i = 1'b1;
        div_op_i = OP_DIVU;
        op_a_i = $urandom;
        op_b_i = 32'($urandom_range(1, 1000));
        @(posedge clk); #1;
        div_valid_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        total_cnt++;
        if (ready_o !== 1'b0) $display("FAIL reset_mid_busy got %b want 0", ready_o); else pass_cnt++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total_cnt++;
        if (ready_o !== 1'b1 || result_o !== 32'd0)
            $display("FAIL reset_mid_state got ready=%b result=%h want ready=1 result=0", ready_o, result_o);
        else pass_cnt++;
        total_cnt++;
        if (alu_operator_o !== ALU_ADD) $display("FAIL reset_mid_alu got %h want %h", alu_operator_o, ALU_ADD); else pass_cnt++;
        do_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b0, lat, res, st);
        total_cnt++;
        if (res !== 32'd14) $display("FAIL reset_mid_fresh_result got %h want %h", res, 32'd14); else pass_cnt++;
        total_cnt++;
        if (lat != ref_latency(OP_DIVU, 32'd100, 32'd7))
            $display("FAIL reset_mid_fresh_latency got %0d want %0d", lat, ref_latency(OP_DIVU, 32'd100, 32'd7));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_backpressure();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout reached before summary");
        $fatal(1);
    end

endmodule
